// File: rtl/mem_arbiter_if.sv
// Bundle of requester, memory and status signals around mem_arbiter.
// slave: the arbiter's view; master: the environment (requesters + memory).
interface mem_arbiter_if;
  // instruction side
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_rvalid;
  logic        i_done;
  // data side
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_wnext;
  logic [15:0] d_rdata;
  logic        d_rvalid;
  logic        d_done;
  // shared memory port
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rdy;
  // status
  logic        busy;
  logic        err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    output i_rdata, i_rvalid, i_done, d_wnext, d_rdata, d_rvalid, d_done,
    output mem_addr, mem_re, mem_we, mem_wdata, busy, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    input  i_rdata, i_rvalid, i_done, d_wnext, d_rdata, d_rvalid, d_done,
    input  mem_addr, mem_re, mem_we, mem_wdata, busy, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Instruction/data burst arbiter sharing one memory port. Each grant runs a
// BEATS-word line burst (fill or writeback) with a per-beat wait timeout.
module mem_arbiter #(
  parameter int BEATS   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int              BW         = $clog2(BEATS);
  localparam logic [BW-1:0]   LAST_BEAT  = BW'(BEATS - 1);
  localparam logic [15:0]     WAIT_LIMIT = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    I_RD = 3'd1,
    D_RD = 3'd2,
    D_WR = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [15:0]    wait_q, wait_d;
  logic [15-BW:0] tag_q, tag_d;             // line address without beat bits
  logic           owner_q, owner_d;         // 1 = data side owns the burst
  logic           last_grant_q, last_grant_d; // 1 = data side won last
  logic           err_q, err_d;
  logic [15:0]    i_rdata_q, i_rdata_d;
  logic [15:0]    d_rdata_q, d_rdata_d;
  logic           i_rvalid_q, i_rvalid_d;
  logic           d_rvalid_q, d_rvalid_d;

  logic active_s;
  logic grant_data_s;
  logic timeout_s;
  logic last_beat_s;

  assign active_s     = (state_q == I_RD) || (state_q == D_RD) || (state_q == D_WR);
  // On a tie the side that did not win last time gets the grant.
  assign grant_data_s = bus.d_req && (!bus.i_req || !last_grant_q);
  assign timeout_s    = !bus.mem_rdy && (wait_q == WAIT_LIMIT);
  assign last_beat_s  = (beat_q == LAST_BEAT);

  // Next-state, beat/wait counters, grant latching and the sticky timeout flag.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    wait_d       = wait_q;
    tag_d        = tag_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        wait_d = 16'h0000;
        if (bus.i_req || bus.d_req) begin
          owner_d      = grant_data_s;
          last_grant_d = grant_data_s;
          if (grant_data_s) begin
            tag_d   = bus.d_addr[15:BW];
            state_d = bus.d_we ? D_WR : D_RD;
          end else begin
            tag_d   = bus.i_addr[15:BW];
            state_d = I_RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      I_RD, D_RD, D_WR: begin
        if (bus.mem_rdy) begin
          wait_d = 16'h0000;
          if (last_beat_s) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else if (timeout_s) begin
          wait_d  = 16'h0000;
          beat_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture read data for whichever side owns the beat completing this cycle.
  always_comb begin
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (bus.mem_rdy && (state_q == I_RD)) begin
      i_rvalid_d = 1'b1;
      i_rdata_d  = bus.mem_rdata;
    end else if (bus.mem_rdy && (state_q == D_RD)) begin
      d_rvalid_d = 1'b1;
      d_rdata_d  = bus.mem_rdata;
    end else begin
      i_rvalid_d = 1'b0;
      d_rvalid_d = 1'b0;
    end
  end

  // State and datapath registers; reset abandons any burst and zeroes all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      wait_q       <= 16'h0000;
      tag_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
      i_rdata_q    <= 16'h0000;
      d_rdata_q    <= 16'h0000;
      i_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      wait_q       <= wait_d;
      tag_q        <= tag_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_rvalid_q   <= i_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
    end
  end

  // Memory port is decoded from the state so it is quiet in IDLE and DONE.
  assign bus.mem_re    = (state_q == I_RD) || (state_q == D_RD);
  assign bus.mem_we    = (state_q == D_WR);
  assign bus.mem_addr  = active_s ? {tag_q, beat_q} : 16'h0000;
  assign bus.mem_wdata = (state_q == D_WR) ? bus.d_wdata : 16'h0000;
  assign bus.d_wnext   = (state_q == D_WR) && bus.mem_rdy;

  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_rvalid  = i_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.i_done    = (state_q == DONE) && !owner_q;
  assign bus.d_done    = (state_q == DONE) && owner_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter. The model works per burst: it decides the
// winner from the request rules, walks beats 0..BEATS-1 while counting waits,
// and predicts the memory port, strobes, done pulse and the gap that follow.
module tb_mem_arbiter;
  localparam int BEATS   = 4;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.BEATS(BEATS), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          last_d_m;   // model: data side won the last grant
  bit          err_m;      // model: sticky timeout flag
  logic [15:0] wbase_m;    // first writeback word of the current burst

  // Single comparison point: counts and reports.
  task automatic chk_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Contents of the modelled memory.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC35A;
  endfunction

  // One clock: after the edge, answer as memory/requester, then let outputs settle.
  task automatic tick(input bit rdy, input logic [15:0] wdata);
    @(posedge clk);
    #1;
    bus.mem_rdy   = rdy;
    bus.mem_rdata = mem_word(bus.mem_addr);
    bus.d_wdata   = wdata;
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk_eq({tag, " busy"},     16'(bus.busy),     16'(0));
    chk_eq({tag, " mem_re"},   16'(bus.mem_re),   16'(0));
    chk_eq({tag, " mem_we"},   16'(bus.mem_we),   16'(0));
    chk_eq({tag, " i_done"},   16'(bus.i_done),   16'(0));
    chk_eq({tag, " d_done"},   16'(bus.d_done),   16'(0));
    chk_eq({tag, " i_rvalid"}, 16'(bus.i_rvalid), 16'(0));
    chk_eq({tag, " d_rvalid"}, 16'(bus.d_rvalid), 16'(0));
    chk_eq({tag, " err"},      16'(bus.err),      16'(err_m));
  endtask

  // Hold reset for two cycles and check every output is zero.
  task automatic do_reset();
    rst        = 1'b1;
    bus.i_req  = 1'b0;
    bus.d_req  = 1'b0;
    err_m      = 1'b0;
    last_d_m   = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 16'h0000);
      chk_quiet("rst");
      chk_eq("rst mem_addr",  bus.mem_addr,  16'h0000);
      chk_eq("rst mem_wdata", bus.mem_wdata, 16'h0000);
      chk_eq("rst i_rdata",   bus.i_rdata,   16'h0000);
      chk_eq("rst d_rdata",   bus.d_rdata,   16'h0000);
      chk_eq("rst d_wnext",   16'(bus.d_wnext), 16'(0));
    end
    rst = 1'b0;
  endtask

  // Run one burst from an IDLE sample with requests already set.
  // mode: 0 rdy always, 1 rdy every other cycle, 2 random, 3 never.
  task automatic run(input int mode, input int drop_at, input bit scramble, input int rst_at);
    bit          own_d, we, rdy, aborted, pend;
    logic [15:0] base, exp_a, pend_data;
    int          beat, waits, cyc;
    own_d     = bus.d_req && (!bus.i_req || !last_d_m);
    last_d_m  = own_d;
    we        = own_d && bus.d_we;
    base      = (own_d ? bus.d_addr : bus.i_addr) & ~16'(BEATS - 1);
    beat      = 0;
    waits     = 0;
    cyc       = 0;
    pend      = 1'b0;
    pend_data = 16'h0000;
    aborted   = 1'b0;
    while (beat < BEATS && !aborted) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 2) == 1);
        2:       rdy = ($urandom_range(0, 2) != 0);
        default: rdy = 1'b0;
      endcase
      tick(rdy, wbase_m + 16'(beat));
      exp_a = base | 16'(beat);
      chk_eq("mem_addr", bus.mem_addr, exp_a);
      chk_eq("mem_re", 16'(bus.mem_re), 16'(!we));
      chk_eq("mem_we", 16'(bus.mem_we), 16'(we));
      chk_eq("busy", 16'(bus.busy), 16'(1));
      chk_eq("err", 16'(bus.err), 16'(err_m));
      chk_eq("i_done early", 16'(bus.i_done), 16'(0));
      chk_eq("d_done early", 16'(bus.d_done), 16'(0));
      chk_eq("i_rvalid", 16'(bus.i_rvalid), 16'(pend && !own_d));
      chk_eq("d_rvalid", 16'(bus.d_rvalid), 16'(pend && own_d));
      if (pend) chk_eq("rdata", own_d ? bus.d_rdata : bus.i_rdata, pend_data);
      if (we) begin
        chk_eq("mem_wdata", bus.mem_wdata, wbase_m + 16'(beat));
        chk_eq("d_wnext", 16'(bus.d_wnext), 16'(rdy));
      end else begin
        chk_eq("d_wnext rd", 16'(bus.d_wnext), 16'(0));
      end
      if (rst_at >= 0 && beat == rst_at) begin
        do_reset();
        return;
      end
      pend      = rdy && !we;
      pend_data = mem_word(exp_a);
      cyc++;
      if (rdy) begin
        beat++;
        waits = 0;
      end else begin
        waits++;
        if (waits == TIMEOUT) begin
          aborted = 1'b1;
          err_m   = 1'b1;
        end
      end
      if (drop_at > 0 && beat == drop_at) begin
        if (own_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
      end
      if (scramble) begin
        if (own_d) begin
          bus.d_addr = 16'($urandom);
          bus.d_we   = 1'($urandom);
        end else begin
          bus.i_addr = 16'($urandom);
        end
      end
    end
    // DONE cycle
    tick(1'($urandom), 16'($urandom));
    chk_eq("done busy", 16'(bus.busy), 16'(1));
    chk_eq("done mem_re", 16'(bus.mem_re), 16'(0));
    chk_eq("done mem_we", 16'(bus.mem_we), 16'(0));
    chk_eq("done d_wnext", 16'(bus.d_wnext), 16'(0));
    chk_eq("i_done", 16'(bus.i_done), 16'(!own_d));
    chk_eq("d_done", 16'(bus.d_done), 16'(own_d));
    chk_eq("last i_rvalid", 16'(bus.i_rvalid), 16'(pend && !own_d));
    chk_eq("last d_rvalid", 16'(bus.d_rvalid), 16'(pend && own_d));
    if (pend) chk_eq("last rdata", own_d ? bus.d_rdata : bus.i_rdata, pend_data);
    chk_eq("done err", 16'(bus.err), 16'(err_m));
    if (own_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
    // mandatory IDLE gap
    tick(1'($urandom), 16'($urandom));
    chk_quiet("gap");
  endtask

  initial begin
    bus.i_req     = 1'b0;
    bus.i_addr    = 16'h0000;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = 16'h0000;
    bus.d_wdata   = 16'h0000;
    bus.mem_rdata = 16'h0000;
    bus.mem_rdy   = 1'b0;
    wbase_m       = 16'h0000;
    do_reset();

    // line fill, zero-wait memory
    bus.i_req = 1'b1; bus.i_addr = 16'h1236;
    run(0, -1, 1'b0, -1);

    // tie after reset: I first, then D; repeated tie goes to I again
    bus.i_req = 1'b1; bus.i_addr = 16'h2000;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h3004;
    run(0, -1, 1'b0, -1);
    run(0, -1, 1'b0, -1);
    bus.i_req = 1'b1; bus.i_addr = 16'h2100;
    bus.d_req = 1'b1; bus.d_addr = 16'h3108;
    run(2, -1, 1'b0, -1);
    run(2, -1, 1'b0, -1);

    // writeback of 0xA0..0xA3, memory ready every other cycle
    wbase_m = 16'h00A0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0040;
    run(1, -1, 1'b0, -1);

    // memory never ready: abort and sticky err
    bus.i_req = 1'b1; bus.i_addr = 16'h0500;
    run(3, -1, 1'b0, -1);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0604;
    run(0, -1, 1'b0, -1);

    // request dropped after beat 0 and inputs scrambled mid-burst
    bus.i_req = 1'b1; bus.i_addr = 16'h0700;
    run(2, 1, 1'b1, -1);

    // random traffic
    for (int n = 0; n < 30; n++) begin
      bus.i_req  = 1'($urandom);
      bus.d_req  = 1'($urandom);
      if (!bus.i_req && !bus.d_req) bus.d_req = 1'b1;
      bus.i_addr = 16'($urandom);
      bus.d_addr = 16'($urandom);
      bus.d_we   = 1'($urandom);
      wbase_m    = 16'($urandom);
      run(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom), -1);
    end

    // reset during beat 2 of a data read, then a normal fill
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0880;
    run(0, -1, 1'b0, 2);
    bus.i_req = 1'b1; bus.i_addr = 16'h0990;
    run(1, -1, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
